// File: rtl/core_pkg.sv
// core_pkg: shared register-file widths and the SAD result entry type
package core_pkg;
  localparam int REG_AW = 5;
  localparam int WORD_W = 32;
  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [WORD_W-1:0] value;
  } sad_entry_t;
endpackage

// File: rtl/sad_wb_fifo.sv
// sad_wb_fifo: circular buffer of pending SAD results with per-slot occupancy for hazard checks
module sad_wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     push,
  input  logic                     pop,
  input  sad_entry_t               pushEntry,
  output sad_entry_t               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [REG_AW-1:0]        occDest [DEPTH],
  output logic [DEPTH-1:0]         occValid
);
  localparam int AW = $clog2(DEPTH);
  sad_entry_t mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign count = wrPtr - rdPtr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = wrPtr == rdPtr;
  assign head = mem[rdPtr[AW-1:0]];
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  always_ff @(posedge Clk)
    if (doPush) mem[wrPtr[AW-1:0]] <= pushEntry;
  // A slot is occupied when its distance from the read pointer is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [AW-1:0] off;
    assign off = AW'(i) - rdPtr[AW-1:0];
    assign occValid[i] = {1'b0, off} < count;
    assign occDest[i] = mem[i].dest;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between MEM/WB and queued SAD results
module wb_port_arbiter
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   pipe_reg_write,
  input  logic [REG_AW-1:0]      pipe_write_reg,
  input  logic                   sad_valid,
  input  logic [REG_AW-1:0]      sad_dest,
  input  logic [WORD_W-1:0]      sad_value,
  output logic                   sad_ready,
  input  logic [REG_AW-1:0]      query_rs,
  input  logic [REG_AW-1:0]      query_rt,
  input  logic [REG_AW-1:0]      query_rd,
  output logic                   pend_hit,
  output logic                   frame_shift,
  output logic [WORD_W-1:0]      SAD_WB_value,
  output logic                   wb_reg_write,
  output logic [REG_AW-1:0]      wb_write_reg,
  output logic                   pipe_stall,
  output logic [$clog2(DEPTH):0] pending_count
);
  sad_entry_t head, inEntry;
  logic full, empty, grant, accept;
  logic [REG_AW-1:0] occDest [DEPTH];
  logic [DEPTH-1:0] occValid;
  logic [7:0] starveCnt, starveNext;
  assign inEntry = '{dest: sad_dest, value: sad_value};
  assign sad_ready = !full;
  assign accept = sad_valid && !full;
  assign grant = !empty && !pipe_reg_write;
  // $0 results are acknowledged but never stored
  sad_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk(Clk),
    .Rst(Rst),
    .push(accept && sad_dest != '0),
    .pop(grant),
    .pushEntry(inEntry),
    .head(head),
    .full(full),
    .empty(empty),
    .count(pending_count),
    .occDest(occDest),
    .occValid(occValid)
  );
  function automatic logic hits(input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] rs,
                                input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd);
    return d != '0 && (d == rs || d == rt || d == rd);
  endfunction
  always_comb begin
    frame_shift = grant;
    SAD_WB_value = grant ? head.value : '0;
    wb_reg_write = grant || pipe_reg_write;
    wb_write_reg = grant ? head.dest : pipe_write_reg;
    starveNext = (empty || grant) ? '0 :
                 (starveCnt == 8'(STARVE_LIMIT)) ? starveCnt : starveCnt + 1'b1;
    pend_hit = accept && hits(sad_dest, query_rs, query_rt, query_rd);
    for (int i = 0; i < DEPTH; i++)
      pend_hit = pend_hit || (occValid[i] && hits(occDest[i], query_rs, query_rt, query_rd));
  end
  // Stall tracks a saturated counter, so it drops on the edge that takes the grant
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      starveCnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      starveCnt <= starveNext;
      pipe_stall <= starveNext == 8'(STARVE_LIMIT);
    end
endmodule
